iomem_ctrl: RTL

Peripheral-bus controller between the PicoSoC `iomem_*` port and up to NSLOTS memory-mapped peripherals (GPIO, LEDs, clock, PWM, …). It decodes the 0x0300_xxxx window into 256-byte slots and sequences one transaction at a time. Each transaction runs a select/ready handshake with the addressed slave. A watchdog terminates stalled accesses with an error word so the CPU never hangs. It replaces the inline per-peripheral `if` chain in the top level.

---
 rtl/iomem_ctrl_pkg.sv | 20 ++
 rtl/iomem_watchdog.sv | 35 +++
 rtl/iomem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/iomem_ctrl_pkg.sv
// rtl/iomem_ctrl_pkg.sv - shared types and constants for the iomem peripheral-bus controller
package iomem_ctrl_pkg;

  localparam int SLOT_W = 8;

  localparam logic [15:0] ERR_UNMAPPED = 16'hBAD0;
  localparam logic [15:0] ERR_TIMEOUT  = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// rtl/iomem_watchdog.sv - access timer that flags a stalled slave after TIMEOUT cycles
module iomem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (enable_i) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = (timer_q == LAST);

endmodule

// File: rtl/iomem_ctrl.sv
// rtl/iomem_ctrl.sv - decodes the iomem window into slots and sequences one slave access at a time
module iomem_ctrl
  import iomem_ctrl_pkg::*;
#(
  parameter int          NSLOTS  = 4,
  parameter logic [15:0] BASE    = 16'h0300,
  parameter int          TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   iomem_valid,
  output logic                   iomem_ready,
  input  logic [3:0]             iomem_wstrb,
  input  logic [31:0]            iomem_addr,
  input  logic [31:0]            iomem_wdata,
  output logic [31:0]            iomem_rdata,
  output logic [NSLOTS-1:0]      s_sel,
  output logic [7:0]             s_addr,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_wdata,
  input  logic [32*NSLOTS-1:0]   s_rdata,
  input  logic [NSLOTS-1:0]      s_ready,
  output logic [7:0]             err_count,
  output logic [7:0]             err_slot
);

  state_e              state_q, state_d;
  logic [NSLOTS-1:0]   sel_q, sel_d;
  logic [7:0]          addr_q, addr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [7:0]          err_slot_q, err_slot_d;
  logic                wd_clear, wd_enable, wd_expired;
  logic [SLOT_W-1:0]   req_slot;
  logic [31:0]         sel_rdata;

  assign req_slot = iomem_addr[15:8];

  iomem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  // sel_q is one-hot, so at most one slice is picked.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (sel_q[i]) sel_rdata = s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    slot_d      = slot_q;
    err_count_d = err_count_q;
    err_slot_d  = err_slot_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iomem_valid && !iomem_ready && iomem_addr[31:16] == BASE) begin
          addr_d  = iomem_addr[7:0];
          wstrb_d = iomem_wstrb;
          wdata_d = iomem_wdata;
          slot_d  = req_slot;
          if (int'(req_slot) < NSLOTS) begin
            for (int i = 0; i < NSLOTS; i++) sel_d[i] = (req_slot == SLOT_W'(i));
            wd_clear = 1'b1;
            state_d  = ACCESS;
          end else begin
            rdata_d     = {ERR_UNMAPPED, 8'h00, req_slot};
            err_count_d = sat_inc(err_count_q);
            err_slot_d  = req_slot;
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        if (|(s_ready & sel_q)) begin
          rdata_d = sel_rdata;
          sel_d   = '0;
          state_d = RESP;
        end else if (wd_expired) begin
          rdata_d     = {ERR_TIMEOUT, 8'h00, slot_q};
          err_count_d = sat_inc(err_count_q);
          err_slot_d  = slot_q;
          sel_d       = '0;
          state_d     = RESP;
        end else begin
          wd_enable = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      slot_q      <= '0;
      err_count_q <= '0;
      err_slot_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      slot_q      <= slot_d;
      err_count_q <= err_count_d;
      err_slot_q  <= err_slot_d;
    end
  end

  assign iomem_ready = (state_q == RESP);
  assign iomem_rdata = rdata_q;
  assign s_sel       = sel_q;
  assign s_addr      = addr_q;
  assign s_wstrb     = wstrb_q;
  assign s_wdata     = wdata_q;
  assign err_count   = err_count_q;
  assign err_slot    = err_slot_q;

endmodule
